// File: rtl/int_to_fp.sv
// int_to_fp: 16-bit two's-complement integer to 1/4/8 float (value = sign * 0.frac * 2^exp).
// Normalizes by shifting one bit per cycle, then holds the result until the consumer takes it.
module int_to_fp (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        sign_out,
  output logic [3:0]  exp_out,
  output logic [7:0]  frac_out,
  output logic        inexact
);

  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;

  typedef struct packed {
    logic       sign;
    logic [3:0] exp;
    logic [7:0] frac;
    logic       inexact;
  } fp_res_t;

  state_t      state_q, state_d;
  logic        sgn_r;
  logic [15:0] mag_r;
  logic [4:0]  k_r;
  fp_res_t     res_q, res_d;
  logic        accept, finish, out_fire;
  logic [15:0] abs_in;
  logic [3:0]  exp_calc;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  // 0x8000 negates to itself, which is exactly the unsigned magnitude we want.
  assign abs_in   = in_data[15] ? (~in_data + 16'd1) : in_data;
  // k_r is at most 15 once bit 15 is set, so 16-k_r fits in 1..15 after truncation.
  assign exp_calc = 4'(5'd16 - k_r);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and selection of the result to capture on leaving SHIFT
  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    res_d   = res_q;
    case (state_q)
      IDLE: if (accept) state_d = SHIFT;
      SHIFT: begin
        if (mag_r == 16'd0) begin
          finish = 1'b1;
          res_d  = '0;
        end else if (mag_r[15] && k_r == 5'd0) begin
          // Only -32768 lands here: magnitude 2^15 does not fit 0.frac * 2^15.
          finish = 1'b1;
          res_d  = '{1'b1, 4'hF, 8'hFF, 1'b1};
        end else if (mag_r[15]) begin
          finish = 1'b1;
          res_d  = '{sgn_r, exp_calc, mag_r[15:8], |mag_r[7:0]};
        end
        if (finish) state_d = DONE;
      end
      DONE: if (out_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and the one-bit-per-cycle normalizing shift
  always_ff @(posedge clk) begin
    if (reset) begin
      sgn_r <= 1'b0;
      mag_r <= '0;
      k_r   <= '0;
    end else if (accept) begin
      sgn_r <= in_data[15];
      mag_r <= abs_in;
      k_r   <= '0;
    end else if (state_q == SHIFT && !finish) begin
      mag_r <= mag_r << 1;
      k_r   <= k_r + 5'd1;
    end
  end

  // Result registers; they keep their last value after the handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      res_q     <= '0;
      out_valid <= 1'b0;
    end else if (finish) begin
      res_q     <= res_d;
      out_valid <= 1'b1;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  assign sign_out = res_q.sign;
  assign exp_out  = res_q.exp;
  assign frac_out = res_q.frac;
  assign inexact  = res_q.inexact;

endmodule

// File: tb/tb_int_to_fp.sv
// Bench for int_to_fp: directed vectors plus randomized values against an arithmetic model.
module tb_int_to_fp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        sign_out;
  logic [3:0]  exp_out;
  logic [7:0]  frac_out;
  logic        inexact;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cyc = 0;

  int_to_fp dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .frac_out(frac_out), .inexact(inexact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: value = sign * 0.frac * 2^exp with exp = bit length of |x|, truncating.
  task automatic model(input logic [15:0] d, output logic s, output logic [3:0] e,
                       output logic [7:0] f, output logic ix, output int lat);
    int v, mag, n, scaled;
    v = int'($signed(d));
    if (v == 0) begin
      s = 0; e = 0; f = 0; ix = 0; lat = 1;
    end else if (v == -32768) begin
      s = 1; e = 15; f = 8'hFF; ix = 1; lat = 1;
    end else begin
      mag = (v < 0) ? -v : v;
      n = 0;
      while ((1 << n) <= mag) n++;
      scaled = mag * 256;
      f   = 8'(scaled >> n);
      ix  = ((int'(f) << n) != scaled);
      s   = (v < 0);
      e   = 4'(n);
      lat = 17 - n;
    end
  endtask

  // Drives one conversion from IDLE (called #1 after an edge); returns what the DUT showed.
  task automatic run_conv(input logic [15:0] d, output int lat, output logic s,
                          output logic [3:0] e, output logic [7:0] f, output logic ix,
                          output logic rdy_bad);
    in_data = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 16'($urandom);
    acc_cyc = cyc;
    lat = -1; rdy_bad = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      if (in_ready) rdy_bad = 1'b1;
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    if (in_ready) rdy_bad = 1'b1;
    s = sign_out; e = exp_out; f = frac_out; ix = inexact;
    if (out_ready && lat > 0) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, sign_out, exp_out, frac_out, inexact} !== 15'd0) begin
      failures++;
      $display("FAIL reset_outputs: got %b, want all zero",
               {out_valid, sign_out, exp_out, frac_out, inexact});
    end
    reset = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready: got %b, want 1", in_ready);
    end
  endtask

  task automatic test_directed;
    logic [15:0] vec [6] = '{16'h0001, 16'hFC18, 16'h00FF, 16'h7FFF, 16'h8000, 16'h0000};
    logic        es   [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  ee   [6] = '{4'd1, 4'd10, 4'd8, 4'd15, 4'd15, 4'd0};
    logic [7:0]  ef   [6] = '{8'h80, 8'hFA, 8'hFF, 8'hFF, 8'hFF, 8'h00};
    logic        ei   [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int          el   [6] = '{16, 7, 9, 2, 1, 1};
    int lat; logic s, ix, rb; logic [3:0] e; logic [7:0] f;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      run_conv(vec[i], lat, s, e, f, ix, rb);
      checks++;
      if (lat !== el[i]) begin
        failures++;
        $display("FAIL directed_latency %h: got %0d, want %0d", vec[i], lat, el[i]);
      end
      checks++;
      if ({s, e, f, ix} !== {es[i], ee[i], ef[i], ei[i]}) begin
        failures++;
        $display("FAIL directed_result %h: got s=%b e=%0d f=%h ix=%b, want s=%b e=%0d f=%h ix=%b",
                 vec[i], s, e, f, ix, es[i], ee[i], ef[i], ei[i]);
      end
      checks++;
      if (rb !== 1'b0) begin
        failures++;
        $display("FAIL directed_in_ready_busy %h: got in_ready high while busy, want 0", vec[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [15:0] d; int lat, mlat; logic s, ix, rb, ms, mix;
    logic [3:0] e, me; logic [7:0] f, mf;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom) >> $urandom_range(0, 15);
      if ($urandom_range(0, 1) == 1) d = -d;
      model(d, ms, me, mf, mix, mlat);
      run_conv(d, lat, s, e, f, ix, rb);
      checks++;
      if (lat !== mlat || {s, e, f, ix} !== {ms, me, mf, mix} || rb !== 1'b0) begin
        failures++;
        $display("FAIL random %h: got lat=%0d s=%b e=%0d f=%h ix=%b busy_rdy=%b, want lat=%0d s=%b e=%0d f=%h ix=%b",
                 d, lat, s, e, f, ix, rb, mlat, ms, me, mf, mix);
      end
    end
  endtask

  task automatic test_backpressure;
    int lat; logic s, ix, rb; logic [3:0] e; logic [7:0] f;
    out_ready = 1'b0;
    run_conv(16'h0123, lat, s, e, f, ix, rb);
    checks++;
    if (lat !== 8 || {s, e, f, ix} !== {1'b0, 4'd9, 8'h91, 1'b1}) begin
      failures++;
      $display("FAIL bp_result: got lat=%0d s=%b e=%0d f=%h ix=%b, want lat=8 s=0 e=9 f=91 ix=1",
               lat, s, e, f, ix);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; in_data = 16'($urandom);
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, sign_out, exp_out, frac_out, inexact} !== {2'b10, 1'b0, 4'd9, 8'h91, 1'b1}) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: got v=%b rdy=%b s=%b e=%0d f=%h ix=%b, want v=1 rdy=0 s=0 e=9 f=91 ix=1",
                 i, out_valid, in_ready, sign_out, exp_out, frac_out, inexact);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_release: got rdy=%b v=%b, want rdy=1 v=0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid;
    int lat; logic s, ix, rb; logic [3:0] e; logic [7:0] f;
    out_ready = 1'b1;
    in_data = 16'h0001; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1; in_data = 16'h0007; in_valid = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, sign_out, exp_out, frac_out, inexact} !== 15'd0) begin
      failures++;
      $display("FAIL reset_mid_outputs: got %b, want all zero",
               {out_valid, sign_out, exp_out, frac_out, inexact});
    end
    reset = 1'b0; in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_in_ready: got %b, want 1", in_ready);
    end
    run_conv(16'h0040, lat, s, e, f, ix, rb);
    checks++;
    if (lat !== 10 || {s, e, f, ix} !== {1'b0, 4'd7, 8'h80, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid_next: got lat=%0d s=%b e=%0d f=%h ix=%b, want lat=10 s=0 e=7 f=80 ix=0",
               lat, s, e, f, ix);
    end
    // Reset while a result is pending in DONE drops it.
    out_ready = 1'b0;
    run_conv(16'h1234, lat, s, e, f, ix, rb);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || exp_out !== 4'd0) begin
      failures++;
      $display("FAIL reset_done: got v=%b rdy=%b e=%0d, want v=0 rdy=1 e=0", out_valid, in_ready, exp_out);
    end
    out_ready = 1'b1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] vec [4] = '{16'h4000, 16'h0003, 16'h8000, 16'h0000};
    int gap [3] = '{4, 17, 3};
    int prev, lat; logic s, ix, rb; logic [3:0] e; logic [7:0] f;
    out_ready = 1'b1;
    run_conv(vec[0], lat, s, e, f, ix, rb);
    prev = acc_cyc;
    for (int i = 1; i < 4; i++) begin
      run_conv(vec[i], lat, s, e, f, ix, rb);
      checks++;
      if (acc_cyc - prev !== gap[i-1]) begin
        failures++;
        $display("FAIL b2b_spacing %h: got %0d cycles, want %0d", vec[i-1], acc_cyc - prev, gap[i-1]);
      end
      prev = acc_cyc;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
